// File: rtl/result_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : result_pkg
//  Description : Shared widths, FIFO entry layout and saturation constant for
//                the result collector.
//  Revision    : 1.0 - initial release
// ============================================================================
package result_pkg;

  localparam int DEFAULT_DATA_W = 40;
  localparam int DEFAULT_OUT_W  = 32;

  // One buffered sample: overflow flag, operation tag, narrowed value.
  typedef struct packed {
    logic                     ovf;
    logic                     sel;
    logic [DEFAULT_OUT_W-1:0] data;
  } entry_t;

  // Value stored in place of an out-of-range result when saturation is built in.
  localparam logic [DEFAULT_OUT_W-1:0] SAT_VALUE = '1;

endpackage
`default_nettype wire

// File: rtl/result_narrow.sv
`default_nettype none
// ============================================================================
//  Module      : result_narrow
//  Description : Unsigned narrowing of a wide arithmetic result. Flags any
//                nonzero bit above OUT_W. Build macro RESULT_COLLECT_SAT_EN
//                selects saturation of flagged values; otherwise the value is
//                truncated.
//  Revision    : 1.0 - initial release
// ============================================================================
module result_narrow
  import result_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int OUT_W  = DEFAULT_OUT_W
) (
  input  logic [DATA_W-1:0] in_data,
  output logic              ovf,
  output logic [OUT_W-1:0]  data
);

  // Overflow detect and narrowed value, purely combinational.
  always_comb begin
    ovf = |in_data[DATA_W-1:OUT_W];
`ifdef RESULT_COLLECT_SAT_EN
    data = ovf ? SAT_VALUE : in_data[OUT_W-1:0];
`else
    data = in_data[OUT_W-1:0];
`endif
  end

endmodule
`default_nettype wire

// File: rtl/result_collector.sv
`default_nettype none
// ============================================================================
//  Module      : result_collector
//  Description : Captures tagged 40-bit results, narrows them to 32 bits and
//                buffers them in a small FIFO drained by valid/ready. The
//                producer cannot be stalled, so samples arriving while full
//                are counted in a saturating drop counter.
//                Build macro RESULT_COLLECT_SAT_EN: saturate instead of
//                truncate on overflow (see result_narrow).
//                OUT_W must match the data width of result_pkg::entry_t.
//  Revision    : 1.0 - initial release
// ============================================================================
module result_collector
  import result_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int OUT_W  = DEFAULT_OUT_W,
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_sel,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_sel,
  output logic                     out_ovf,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  c_depth    = CNT_W'(DEPTH);
  localparam logic [DROP_W-1:0] c_drop_max = '1;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [DROP_W-1:0]  r_drop;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_ovf;
  logic [OUT_W-1:0]   w_narrow;
  entry_t             w_entry;
  entry_t             w_head;

  result_narrow #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) u_narrow (
    .in_data (in_data),
    .ovf     (w_ovf),
    .data    (w_narrow)
  );

  // Full/empty come from occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    w_full  = (r_count == c_depth);
    w_empty = (r_count == '0);
    // in_ready is evaluated before any pop, so full + pop still drops.
    w_push  = in_valid && !w_full;
    w_pop   = out_valid && out_ready;
    w_entry = '{ovf: w_ovf, sel: in_sel, data: w_narrow};
    w_head  = r_mem[r_rd_ptr];
  end

  // Handshake and head outputs; head fields forced to zero while empty.
  always_comb begin
    in_ready  = !w_full;
    out_valid = !w_empty;
    out_data  = w_empty ? '0   : w_head.data;
    out_sel   = w_empty ? 1'b0 : w_head.sel;
    out_ovf   = w_empty ? 1'b0 : w_head.ovf;
    count     = r_count;
    drop_cnt  = r_drop;
  end

  // Storage write; contents are intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (!RST && w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // Pointers, occupancy and saturating drop counter.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (in_valid && w_full && (r_drop != c_drop_max)) begin
        r_drop <= r_drop + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_result_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_result_collector
//  Description : Directed self-checking bench for result_collector.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_result_collector;

  logic        clk;
  logic        RST;
  logic        in_valid;
  logic [39:0] in_data;
  logic        in_sel;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_sel;
  logic        out_ovf;
  logic        out_ready;
  logic [2:0]  count;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  result_collector dut (
    .clk       (clk),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ovf   (out_ovf),
    .out_ready (out_ready),
    .count     (count),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_ovf_data;

  initial begin
`ifdef RESULT_COLLECT_SAT_EN
    exp_ovf_data = 32'hFFFF_FFFF;
`else
    exp_ovf_data = 32'h0000_0005;
`endif
    RST = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = 1'b0; out_ready = 1'b0;
    step(); step();
    RST = 1'b0;

    // Reset state
    chk("rst_count",    count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sel",  out_sel, 0);
    chk("rst_out_ovf",  out_ovf, 0);
    chk("rst_drop",     drop_cnt, 0);

    // 1: single push, visible next cycle
    in_valid = 1'b1; in_data = 40'd10; in_sel = 1'b0; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t1_valid", out_valid, 1);
    chk("t1_data",  out_data, 10);
    chk("t1_sel",   out_sel, 0);
    chk("t1_ovf",   out_ovf, 0);
    chk("t1_count", count, 1);
    step();
    chk("t1_popped", count, 0);

    // 2: overflowing value
    in_valid = 1'b1; in_data = 40'h01_0000_0005; in_sel = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t2_ovf",  out_ovf, 1);
    chk("t2_data", out_data, exp_ovf_data);
    chk("t2_sel",  out_sel, 1);
    step();
    chk("t2_empty", out_valid, 0);
    // empty with out_ready high must not underflow
    step();
    chk("t2_no_underflow", count, 0);

    // 3: overfill with 6 values, consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 40'(100 + i); in_sel = i[0];
      step();
    end
    chk("t3_count",    count, 4);
    chk("t3_in_ready", in_ready, 0);
    chk("t3_drop",     drop_cnt, 2);
    chk("t3_head",     out_data, 100);
    // full + pop on the same edge: incoming sample still dropped
    in_valid = 1'b1; in_data = 40'd999; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t3_fullpop_count", count, 3);
    chk("t3_fullpop_drop",  drop_cnt, 3);
    for (int i = 1; i < 4; i++) begin
      chk("t3_drain_data", out_data, 100 + i);
      chk("t3_drain_sel",  out_sel, i % 2);
      step();
    end
    chk("t3_drained", out_valid, 0);

    // 4: occupancy 2, simultaneous push/pop across pointer wrap
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 40'd200; step();
    in_data = 40'd201; step();
    chk("t4_occ", count, 2);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_data = 40'(202 + k);
      chk("t4_head", out_data, 200 + k);
      step();
      chk("t4_count", count, 2);
    end
    in_valid = 1'b0;
    chk("t4_tail0", out_data, 208);
    step();
    chk("t4_tail1", out_data, 209);
    step();
    chk("t4_empty", count, 0);

    // 5: drop counter saturation (starts at 3)
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 40'(300 + i); step();
    end
    chk("t5_full", count, 4);
    for (int i = 0; i < 251; i++) step();
    chk("t5_drop_254", drop_cnt, 254);
    for (int i = 0; i < 49; i++) step();
    chk("t5_drop_sat", drop_cnt, 255);
    chk("t5_head", out_data, 300);
    in_valid = 1'b0;

    // 6: reset mid-operation with occupancy 3 and in_valid high
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t6_occ", count, 3);
    RST = 1'b1; in_valid = 1'b1; in_data = 40'd77;
    step();
    RST = 1'b0; in_valid = 1'b0;
    chk("t6_count",     count, 0);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_drop",      drop_cnt, 0);
    chk("t6_in_ready",  in_ready, 1);
    chk("t6_out_data",  out_data, 0);
    step();
    chk("t6_not_stored", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
